// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings, init nibbles, timing defaults and db field indices
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT  = 4'd0,
    ST_INIT_NIB  = 4'd1,
    ST_INIT_WAIT = 4'd2,
    ST_IDLE      = 4'd3,
    ST_ARM       = 4'd4,
    ST_U_NIB     = 4'd5,
    ST_GAP       = 4'd6,
    ST_L_NIB     = 4'd7,
    ST_EXEC      = 4'd8,
    ST_DONE      = 4'd9
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_E_HIGH = 2'd2
  } strobe_phase_e;

  localparam logic [3:0] INIT_NIB_HI = 4'h3;
  localparam logic [3:0] INIT_NIB_LO = 4'h2;

  localparam int unsigned DEF_T_POWERUP    = 750000;
  localparam int unsigned DEF_T_INIT_LONG  = 205000;
  localparam int unsigned DEF_T_INIT_SHORT = 5000;
  localparam int unsigned DEF_T_INIT_40US  = 2000;
  localparam int unsigned DEF_T_SETUP      = 2;
  localparam int unsigned DEF_T_E_HIGH     = 12;
  localparam int unsigned DEF_T_GAP        = 50;
  localparam int unsigned DEF_T_EXEC       = 2000;
  localparam int unsigned DEF_CNT_W        = 20;

  localparam int RS_BIT = 9;
  localparam int RW_BIT = 8;

endpackage

// File: rtl/lcd_nibble_strobe.sv
// rtl/lcd_nibble_strobe.sv - drives one nibble onto the LCD pins: setup, E high, release
module lcd_nibble_strobe
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [3:0] nibble_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic       tc_i,
  output logic       setup_o,
  output logic       e_high_o,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [3:0] sf_d_o
);

  strobe_phase_e phase_q, phase_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic [3:0]    nib_q, nib_d;

  // Pins only change on start, so RS/RW/data stay put after E falls.
  always_comb begin
    phase_d = phase_q;
    e_d     = e_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    nib_d   = nib_q;
    done_o  = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        if (start_i) begin
          phase_d = PH_SETUP;
          nib_d   = nibble_i;
          rs_d    = rs_i;
          rw_d    = rw_i;
        end
      end
      PH_SETUP: begin
        if (tc_i) begin
          phase_d = PH_E_HIGH;
          e_d     = 1'b1;
        end
      end
      PH_E_HIGH: begin
        if (tc_i) begin
          phase_d = PH_IDLE;
          e_d     = 1'b0;
          done_o  = 1'b1;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        e_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      nib_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      nib_q   <= nib_d;
    end
  end

  assign setup_o  = (phase_q == PH_SETUP);
  assign e_high_o = (phase_q == PH_E_HIGH);
  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_rw_o = rw_q;
  assign sf_d_o   = nib_q;

endmodule

// File: rtl/lcd_instruction_tx.sv
// rtl/lcd_instruction_tx.sv - HD44780 4-bit power-on init and instruction serializer
module lcd_instruction_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP    = DEF_T_POWERUP,
  parameter int unsigned T_INIT_LONG  = DEF_T_INIT_LONG,
  parameter int unsigned T_INIT_SHORT = DEF_T_INIT_SHORT,
  parameter int unsigned T_INIT_40US  = DEF_T_INIT_40US,
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_E_HIGH     = DEF_T_E_HIGH,
  parameter int unsigned T_GAP        = DEF_T_GAP,
  parameter int unsigned T_EXEC       = DEF_T_EXEC,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_instruction,
  input  logic [9:0] db,
  output logic       done,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] sf_d
);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic [5:0]       cap_q, cap_d;

  logic             start;
  logic [3:0]       nib;
  logic             st_rs, st_rw;
  logic             sub_setup, sub_e, sub_done;
  logic             timed, tc;
  logic [CNT_W-1:0] limit;

  // One timer serves every timed phase; the strobe's phases take priority.
  always_comb begin
    timed = 1'b1;
    limit = '0;
    if (sub_setup) begin
      limit = CNT_W'(T_SETUP);
    end else if (sub_e) begin
      limit = CNT_W'(T_E_HIGH);
    end else begin
      unique case (state_q)
        ST_PWR_WAIT: limit = CNT_W'(T_POWERUP);
        ST_INIT_WAIT: begin
          unique case (idx_q)
            2'd0:    limit = CNT_W'(T_INIT_LONG);
            2'd1:    limit = CNT_W'(T_INIT_SHORT);
            default: limit = CNT_W'(T_INIT_40US);
          endcase
        end
        ST_GAP:  limit = CNT_W'(T_GAP);
        ST_EXEC: limit = CNT_W'(T_EXEC);
        default: timed = 1'b0;
      endcase
    end
  end

  assign tc      = timed && (timer_q == limit - 1'b1);
  assign timer_d = (start || tc || !timed) ? '0 : timer_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    cap_d       = cap_q;
    start       = 1'b0;
    nib         = INIT_NIB_HI;
    st_rs       = 1'b0;
    st_rw       = 1'b0;
    unique case (state_q)
      ST_PWR_WAIT: begin
        if (tc) begin
          start   = 1'b1;
          state_d = ST_INIT_NIB;
        end
      end
      ST_INIT_NIB: if (sub_done) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (tc) begin
          if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            start   = 1'b1;
            nib     = (idx_q == 2'd2) ? INIT_NIB_LO : INIT_NIB_HI;
            state_d = ST_INIT_NIB;
          end
        end
      end
      ST_IDLE: if (next_instruction) state_d = ST_ARM;
      // db trails the strobe by one cycle, so it is sampled here.
      ST_ARM: begin
        cap_d   = {db[RS_BIT], db[RW_BIT], db[3:0]};
        start   = 1'b1;
        nib     = db[7:4];
        st_rs   = db[RS_BIT];
        st_rw   = db[RW_BIT];
        state_d = ST_U_NIB;
      end
      ST_U_NIB: if (sub_done) state_d = ST_GAP;
      ST_GAP: begin
        if (tc) begin
          start   = 1'b1;
          nib     = cap_q[3:0];
          st_rs   = cap_q[5];
          st_rw   = cap_q[4];
          state_d = ST_L_NIB;
        end
      end
      ST_L_NIB: if (sub_done) state_d = ST_EXEC;
      ST_EXEC:  if (tc) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PWR_WAIT;
      timer_q     <= '0;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      cap_q       <= 6'h00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      cap_q       <= cap_d;
    end
  end

  lcd_nibble_strobe u_strobe (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .nibble_i (nib),
    .rs_i     (st_rs),
    .rw_i     (st_rw),
    .tc_i     (tc),
    .setup_o  (sub_setup),
    .e_high_o (sub_e),
    .done_o   (sub_done),
    .lcd_e_o  (lcd_e),
    .lcd_rs_o (lcd_rs),
    .lcd_rw_o (lcd_rw),
    .sf_d_o   (sf_d)
  );

  assign done      = (state_q == ST_DONE);
  assign init_done = init_done_q;
  assign busy      = (state_q == ST_ARM) || (state_q == ST_U_NIB) || (state_q == ST_GAP) ||
                     (state_q == ST_L_NIB) || (state_q == ST_EXEC);

endmodule
